paralelo_serial_tx: RTL and testbench
=====================================

Name: paralelo_serial_tx

Overview:
- Transmit-side serializer feeding the receive PHY's serial-to-parallel stage over the single-bit serial link.
- Accepts bytes through a ready/valid handshake and emits them MSB first, one bit per clk_32f cycle.
- After reset it sends a sync preamble of COM characters. Once the preamble is done, it fills bit-times that have no data with IDLE characters.
- The downstream receiver uses the COM characters to reach its active state.

Parameters:
- NUM_COM, 4: number of COM characters sent after reset before data is allowed (range 1..15).
- COM_CHAR, 8'hBC: sync/comma character.
- IDLE_CHAR, 8'h7C: filler character sent in RUN when no byte is pending.

Ports:
- clk_32f  input  1  bit clock; every register in the block uses its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  parallel byte to transmit.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  block accepts data_in this cycle; a transfer happens when valid_in && ready_out.
- data_out  output  1  serial bit stream, MSB first.
- active_out  output  1  high once the preamble is finished (state RUN).
- char_strobe  output  1  one-cycle pulse on the cycle in which the first bit (MSB) of a new character is on data_out.

Behaviour:
- Clock and reset: one clock, clk_32f. reset is asynchronous and active-high.
- Registers:
  - sr[7:0]: shift register.
  - bit_cnt[2:0]: bit position within the current character.
  - com_cnt[3:0]: COM characters sent so far.
  - state: SYNC or RUN.
  - hold_data[7:0]: holding register for an accepted byte.
  - hold_full: holding register occupied.
- Reset values:
  - sr=0, hold_data=0, hold_full=0, com_cnt=0.
  - bit_cnt=7, so that the first edge after reset performs a load.
  - state=SYNC.
- Outputs during reset: data_out=0, active_out=0, ready_out=0, char_strobe=0.
- data_out is sr[7], driven directly from the register with no extra logic.
- Load edge (bit_cnt==7):
  - sr <= selected char, bit_cnt <= 0, char_strobe <= 1 (registered).
  - The first bit of a character therefore appears 1 cycle after the load decision.
- Other edges: sr <= {sr[6:0],1'b0}, bit_cnt <= bit_cnt+1, char_strobe <= 0.
- Character period is exactly 8 cycles; characters follow back to back with no gaps.
- Character selection, state SYNC:
  - Load COM_CHAR and increment com_cnt.
  - On the load where com_cnt==NUM_COM-1, state <= RUN.
  - Exactly NUM_COM COM characters are sent.
- Character selection, state RUN:
  - If hold_full: load hold_data.
  - Otherwise: load IDLE_CHAR.
  - The block never returns to SYNC except through reset.
- active_out = (state==RUN). It rises on the same edge as the last COM load.
- ready_out = (state==RUN) && (!hold_full || bit_cnt==7). It is combinational, so one byte can be accepted per character slot.
- Accept (valid_in && ready_out): hold_data <= data_in, hold_full <= 1.
- Load without accept: hold_full <= 0.
- Simultaneous load and accept:
  - The old hold_data goes into sr.
  - The new byte goes into hold_data, and hold_full stays 1.
  - With the holding register empty at that edge, IDLE is loaded and the new byte goes out in the following slot.
- Throughput: sustained 1 byte per 8 cycles with no loss. When hold_full is set and it is not a load cycle, ready_out=0 and the producer must hold valid_in/data_in.
- Bytes presented during SYNC are not accepted (ready_out=0). They are never dropped silently.
- Reset asserted mid-character:
  - Output is immediately forced to 0 and any pending byte is discarded.
  - After release, a full NUM_COM preamble is resent.

Decomposition:
- Shared package holds:
  - the character constants COM_CHAR=8'hBC and IDLE_CHAR=8'h7C (also used by the receive-side aligner);
  - the SYNC/RUN state encoding.
- No sub-module: shifter, counters and holding register live in one module.

Test Plan:
- Reset release, valid_in=0 for 64 cycles -> data_out carries 10111100 four times (cycles 1-32), then 01111100 repeated. active_out rises at the 4th COM load. char_strobe pulses every 8 cycles.
- valid_in=1 with data_in=8'hA5 held from reset release -> ready_out=0 for the whole preamble. The byte is accepted at the first RUN ready cycle, and 10100101 appears in the slot after acceptance.
- Stream 8'h01, 8'h02, 8'h03 with valid_in always high -> exactly one accept per 8 cycles. Serial stream is 00000001 00000010 00000011 with no IDLE between the bytes once the pipeline is primed.
- Single byte 8'hFF presented on a load cycle while the holding register is empty -> IDLE in the current slot, 11111111 in the next slot, then IDLE resumes.
- reset pulsed in the middle of bit 4 of a data byte with a byte pending in the holding register -> data_out=0 immediately. After release: 4 COM characters, then IDLE; the pending byte never appears.
- NUM_COM=1 -> a single 10111100, then active_out=1 and IDLE/data follow.

Source files
------------

// File: rtl/paralelo_serial_tx_pkg.sv
// paralelo_serial_tx_pkg: character constants and state encoding shared by the serial link blocks
package paralelo_serial_tx_pkg;

    localparam logic [7:0] COM_CHAR  = 8'hBC;
    localparam logic [7:0] IDLE_CHAR = 8'h7C;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: byte-to-serial transmitter, MSB first, COM preamble after reset then IDLE fill
//   clk_32f     : bit clock (rising edge)
//   reset       : asynchronous active-high reset
//   data_in     : byte to send, taken when valid_in && ready_out
//   valid_in    : data_in is valid
//   ready_out   : transmitter accepts data_in this cycle
//   data_out    : serial bit stream
//   active_out  : preamble finished
//   char_strobe : high while the MSB of a new character is on data_out
module paralelo_serial_tx #(
    parameter int         NUM_COM   = 4,
    parameter logic [7:0] COM_CHAR  = paralelo_serial_tx_pkg::COM_CHAR,
    parameter logic [7:0] IDLE_CHAR = paralelo_serial_tx_pkg::IDLE_CHAR
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out,
    output logic       char_strobe
);
    import paralelo_serial_tx_pkg::*;

    state_t     state, state_nxt;
    logic [7:0] sr, hold_data, next_char;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic       hold_full, load, accept, last_com;

    assign load       = bit_cnt == 3'd7;
    assign last_com   = com_cnt == 4'(NUM_COM - 1);
    // A full holding register frees up on the load edge, so a new byte can be taken then
    assign ready_out  = state == RUN && (!hold_full || load);
    assign accept     = valid_in && ready_out;
    assign data_out   = sr[7];
    assign active_out = state == RUN;

    always_comb begin
        state_nxt = state;
        next_char = IDLE_CHAR;
        if (state == SYNC) begin
            next_char = COM_CHAR;
            if (load && last_com) state_nxt = RUN;
        end else if (hold_full) begin
            next_char = hold_data;
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) state <= SYNC;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr          <= 8'd0;
            bit_cnt     <= 3'd7;
            com_cnt     <= 4'd0;
            char_strobe <= 1'b0;
            hold_data   <= 8'd0;
            hold_full   <= 1'b0;
        end else begin
            if (load) begin
                sr          <= next_char;
                bit_cnt     <= 3'd0;
                char_strobe <= 1'b1;
                if (state == SYNC) com_cnt <= com_cnt + 4'd1;
            end else begin
                sr          <= {sr[6:0], 1'b0};
                bit_cnt     <= bit_cnt + 3'd1;
                char_strobe <= 1'b0;
            end
            // An accept on a load edge refills the register the load just emptied
            if (accept) begin
                hold_data <= data_in;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: directed checks of preamble, handshake, streaming, reset and NUM_COM=1
module tb_paralelo_serial_tx;

    logic       clk_32f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       ready_out, data_out, active_out, char_strobe;

    logic       rst1 = 1'b1;
    logic [7:0] data1 = 8'd0;
    logic       valid1 = 1'b0;
    logic       ready1, dout1, act1, strb1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk_32f = ~clk_32f;
    always @(posedge clk_32f) cyc <= cyc + 1;

    paralelo_serial_tx u_dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .active_out(active_out), .char_strobe(char_strobe)
    );

    paralelo_serial_tx #(.NUM_COM(1)) u_dut1 (
        .clk_32f(clk_32f), .reset(rst1), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .data_out(dout1), .active_out(act1), .char_strobe(strb1)
    );

    task automatic get_char(output logic [7:0] c, output logic [7:0] s, output logic a0,
                            output logic r0, output logic rany);
        c = 8'd0; s = 8'd0; a0 = 1'b0; r0 = 1'b0; rany = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_32f); #1;
            c = {c[6:0], data_out};
            s = {s[6:0], char_strobe};
            rany = rany | ready_out;
            if (i == 0) begin a0 = active_out; r0 = ready_out; end
        end
    endtask

    task automatic send(input logic [7:0] b, output int at);
        at = -1;
        data_in = b;
        valid_in = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_32f);
            if (ready_out) begin
                @(posedge clk_32f); #1;
                at = cyc;
                break;
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic do_reset(output int c0);
        @(negedge clk_32f); reset = 1'b1;
        @(negedge clk_32f);
        @(negedge clk_32f); reset = 1'b0;
        c0 = cyc;
    endtask

    task automatic test_reset;
        logic [7:0] c, s;
        logic a0, r0, ra;
        valid_in = 1'b0;
        reset = 1'b1;
        @(negedge clk_32f);
        @(negedge clk_32f);
        n_cmp++; if ({data_out, active_out, ready_out, char_strobe} !== 4'b0000) begin n_err++; $display("FAIL reset_outputs: got %b want 0000", {data_out, active_out, ready_out, char_strobe}); end
        @(negedge clk_32f); reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            get_char(c, s, a0, r0, ra);
            n_cmp++; if (c !== (k < 4 ? 8'hBC : 8'h7C)) begin n_err++; $display("FAIL reset_char%0d: got %h want %h", k, c, (k < 4 ? 8'hBC : 8'h7C)); end
            n_cmp++; if (s !== 8'h80) begin n_err++; $display("FAIL reset_strobe%0d: got %b want 10000000", k, s); end
            n_cmp++; if (a0 !== (k >= 3)) begin n_err++; $display("FAIL reset_active%0d: got %b want %b", k, a0, k >= 3); end
        end
    endtask

    task automatic test_hold_preamble;
        logic [7:0] c, s;
        logic a0, r0, ra;
        @(negedge clk_32f); reset = 1'b1;
        valid_in = 1'b1; data_in = 8'hA5;
        @(negedge clk_32f);
        @(negedge clk_32f); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            get_char(c, s, a0, r0, ra);
            n_cmp++; if (ra !== 1'b0) begin n_err++; $display("FAIL pre_ready%0d: got %b want 0", k, ra); end
        end
        get_char(c, s, a0, r0, ra);
        n_cmp++; if (c !== 8'hBC) begin n_err++; $display("FAIL pre_last_com: got %h want bc", c); end
        n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL pre_first_ready: got %b want 1", r0); end
        valid_in = 1'b0;
        get_char(c, s, a0, r0, ra);
        n_cmp++; if (c !== 8'hA5) begin n_err++; $display("FAIL pre_byte: got %h want a5", c); end
        get_char(c, s, a0, r0, ra);
        n_cmp++; if (c !== 8'h7C) begin n_err++; $display("FAIL pre_after: got %h want 7c", c); end
    endtask

    task automatic test_stream;
        logic [7:0] ch [8];
        logic [7:0] exp_ch [8];
        int c0, a1, a2, a3;
        exp_ch = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h7C};
        do_reset(c0);
        fork
            begin send(8'h01, a1); send(8'h02, a2); send(8'h03, a3); end
            begin
                logic [7:0] s;
                logic a0, r0, ra;
                for (int k = 0; k < 8; k++) get_char(ch[k], s, a0, r0, ra);
            end
        join
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (ch[k] !== exp_ch[k]) begin n_err++; $display("FAIL stream_char%0d: got %h want %h", k, ch[k], exp_ch[k]); end
        end
        n_cmp++; if (a1 - c0 !== 26) begin n_err++; $display("FAIL stream_acc1: got %0d want 26", a1 - c0); end
        n_cmp++; if (a2 - a1 !== 7) begin n_err++; $display("FAIL stream_gap12: got %0d want 7", a2 - a1); end
        n_cmp++; if (a3 - a2 !== 8) begin n_err++; $display("FAIL stream_gap23: got %0d want 8", a3 - a2); end
    endtask

    task automatic test_single_ff;
        logic [7:0] c, s;
        logic a0, r0, ra;
        logic [7:0] exp_ch [3];
        int c0;
        exp_ch = '{8'h7C, 8'hFF, 8'h7C};
        do_reset(c0);
        for (int k = 0; k < 5; k++) get_char(c, s, a0, r0, ra);
        n_cmp++; if (c !== 8'h7C) begin n_err++; $display("FAIL ff_idle_before: got %h want 7c", c); end
        n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL ff_ready_load: got %b want 1", ready_out); end
        data_in = 8'hFF; valid_in = 1'b1;
        fork
            begin @(posedge clk_32f); #1; valid_in = 1'b0; end
            for (int k = 0; k < 3; k++) begin
                get_char(c, s, a0, r0, ra);
                n_cmp++; if (c !== exp_ch[k]) begin n_err++; $display("FAIL ff_char%0d: got %h want %h", k, c, exp_ch[k]); end
            end
        join
    endtask

    task automatic test_reset_mid;
        logic [7:0] c, s;
        logic a0, r0, ra;
        logic [4:0] bits;
        int c0, a1, a2;
        do_reset(c0);
        fork
            begin send(8'h3C, a1); send(8'h55, a2); end
            begin
                for (int k = 0; k < 4; k++) get_char(c, s, a0, r0, ra);
                bits = 5'd0;
                for (int i = 0; i < 5; i++) begin @(posedge clk_32f); #1; bits = {bits[3:0], data_out}; end
            end
        join
        n_cmp++; if (a2 - c0 !== 33) begin n_err++; $display("FAIL mid_pending: got %0d want 33", a2 - c0); end
        n_cmp++; if (bits !== 5'b00111) begin n_err++; $display("FAIL mid_bits: got %b want 00111", bits); end
        #3 reset = 1'b1;
        #2;
        n_cmp++; if ({data_out, active_out, ready_out, char_strobe} !== 4'b0000) begin n_err++; $display("FAIL mid_forced: got %b want 0000", {data_out, active_out, ready_out, char_strobe}); end
        @(negedge clk_32f);
        @(negedge clk_32f); reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            get_char(c, s, a0, r0, ra);
            n_cmp++; if (c !== (k < 4 ? 8'hBC : 8'h7C)) begin n_err++; $display("FAIL mid_char%0d: got %h want %h", k, c, (k < 4 ? 8'hBC : 8'h7C)); end
        end
    endtask

    task automatic test_num_com1;
        logic [23:0] bits;
        bits = 24'd0;
        @(negedge clk_32f);
        n_cmp++; if (act1 !== 1'b0) begin n_err++; $display("FAIL nc1_reset_active: got %b want 0", act1); end
        valid1 = 1'b1; data1 = 8'h96; rst1 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk_32f); #1;
            bits = {bits[22:0], dout1};
            if (i == 0) begin
                n_cmp++; if ({act1, strb1} !== 2'b11) begin n_err++; $display("FAIL nc1_active: got %b want 11", {act1, strb1}); end
            end
            if (i == 1) valid1 = 1'b0;
        end
        n_cmp++; if (bits !== 24'hBC967C) begin n_err++; $display("FAIL nc1_stream: got %h want bc967c", bits); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_hold_preamble;
        test_stream;
        test_single_ff;
        test_reset_mid;
        test_num_com1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
